traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
- Phase sequencer for a four-approach junction: main road (T1, T2) and side road (S1, S2), plus a pedestrian all-red walk phase.
- Main road rests on green. Side-road and pedestrian requests are latched and served with min/max green, yellow and all-red clearance timing.
- Side and pedestrian requests are arbitrated fairly.
- Drives the 3-bit light buses consumed by the junction display logic.

Parameters:
- MIN_GREEN, 4, minimum green cycles for any green phase (>=1)
- MAX_GREEN, 10, maximum side green cycles (>=MIN_GREEN)
- YELLOW_T, 2, yellow cycles
- ALLRED_T, 1, all-red clearance cycles (>=1)
- WALK_T, 5, pedestrian walk cycles
- FLASH_T, 4, half-period of night flash in cycles (used only with macro)
- CNT_W, 8, phase timer width; must hold max(all timing params)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- side_req  in  1  side-road vehicle sensor, level
- ped_req  in  1  pedestrian button, pulse or level
- T1  out  3  main approach 1 lights {R,Y,G}
- T2  out  3  main approach 2 lights, always equal to T1
- S1  out  3  side approach 1 lights {R,Y,G}
- S2  out  3  side approach 2 lights, always equal to S1
- walk  out  1  pedestrian walk lamp
- busy  out  1  high in any state other than MAIN_GREEN

Behaviour:
- Light encoding, one-hot: red 3'b100, yellow 3'b010, green 3'b001. Outputs decode from the registered state, so they change on the same edge as the state.
- States: ALLRED, MAIN_GREEN, MAIN_YELLOW, SIDE_GREEN, SIDE_YELLOW, WALK.
- Phase timer cnt clears to 0 on every state entry and increments each cycle in the state.
- Reset (rst=0, asynchronous):
  - state=ALLRED, cnt=0, next=MAIN.
  - side_pend=0, ped_pend=0, ped_first=0.
  - T1=T2=S1=S2=3'b100, walk=0, busy=1.
- Pending flags:
  - side_pend is set on any cycle side_req=1; ped_pend is set on any cycle ped_req=1.
  - side_pend clears on the edge entering SIDE_GREEN; ped_pend clears on the edge entering WALK.
  - Clear wins over set on that edge: a request sampled on the entry edge is absorbed by the service being granted.
- MAIN_GREEN (T=3'b001, S=3'b100):
  - No timeout.
  - Exits to MAIN_YELLOW when cnt>=MIN_GREEN-1 and (side_pend|ped_pend).
- SIDE_GREEN (S=3'b001, T=3'b100):
  - Exits to SIDE_YELLOW when cnt==MAX_GREEN-1 (max-out).
  - Also exits when cnt>=MIN_GREEN-1 and side_req=0 (gap-out).
- MAIN_YELLOW / SIDE_YELLOW: the active road shows 3'b010 for YELLOW_T cycles, then ALLRED.
- WALK: all lights 3'b100, walk=1 for WALK_T cycles, then ALLRED.
- ALLRED: all red for ALLRED_T cycles, then goes to the destination recorded on entry:
  - Entered from reset, SIDE_YELLOW or WALK: destination is MAIN_GREEN.
  - Entered from MAIN_YELLOW with only side_pend: SIDE_GREEN. With only ped_pend: WALK.
  - Entered from MAIN_YELLOW with both pending: WALK if ped_first=1, else SIDE_GREEN; ped_first then toggles.
- Requests during any phase only set flags; they never shorten yellow, all-red or walk.
- Timer never wraps under legal parameters. Illegal parameters (a value of 0, MIN_GREEN>MAX_GREEN) are unsupported; an elaboration check flags them.
- Reset mid-operation forces the reset values immediately, without waiting for a clock edge. Pending requests are discarded.

Optional Feature:
- Macro TRAFFIC_NIGHT_FLASH_EN.
- With macro:
  - Adds input port night (1 bit) and state FLASH.
  - When night=1 at the exit of ALLRED, enter FLASH instead of the recorded destination.
  - In FLASH, T1/T2 alternate 3'b010 / 3'b000 and S1/S2 alternate 3'b100 / 3'b000, toggling every FLASH_T cycles, starting lit. walk=0, busy=1.
  - Pending flags keep latching but are not served.
  - night=0 leads to ALLRED, then MAIN_GREEN.
  - MAIN_GREEN with night=1 and cnt>=MIN_GREEN-1 goes to MAIN_YELLOW.
- Without macro: no night port, no FLASH state; behaviour exactly as above.

Test Plan:
- Reset: hold rst=0 for 3 edges, then release.
  - During reset: all lights 3'b100, walk=0, busy=1.
  - After release: 1 cycle ALLRED, then T1=T2=3'b001, S=3'b100, busy=0.
- Idle rest: no requests for 50 cycles -> T stays 3'b001 throughout, no transitions.
- Gap-out: 1-cycle side_req pulse at MAIN_GREEN cnt=0.
  - Main green 4 cycles, main yellow 2, all-red 1.
  - Side green 4, side yellow 2, all-red 1, then main green.
- Max-out: side_req held high -> S1=S2=3'b001 for exactly 10 cycles, then 3'b010 for 2 cycles.
- Fairness: side_req and ped_req asserted together, twice, after reset.
  - First service is SIDE_GREEN; next service after main is WALK (walk=1 for 5 cycles, all lights red).
- Async reset mid SIDE_YELLOW: drop rst between clock edges.
  - Outputs go to all 3'b100 before the next edge.
  - After release, side_pend=0: no side service unless re-requested.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: phase sequencer for a main/side junction with a
// pedestrian all-red walk phase. Main road rests on green; side and
// pedestrian requests are latched and served with min/max green, yellow and
// all-red clearance. Optional night flash mode: define TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 5,
  parameter int unsigned FLASH_T   = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic       night,
`endif
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] T1,
  output logic [2:0] T2,
  output logic [2:0] S1,
  output logic [2:0] S2,
  output logic       walk,
  output logic       busy
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_M1 = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_M1  = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WLK_M1 = CNT_W'(WALK_T - 1);

  // Elaboration guard: zero timings, inverted green limits or a timer too narrow.
  if (MIN_GREEN == 0 || MAX_GREEN == 0 || YELLOW_T == 0 || ALLRED_T == 0 ||
      WALK_T == 0 || FLASH_T == 0 || MIN_GREEN > MAX_GREEN || CNT_W == 0 ||
      CNT_W >= 32 ||
      ((MIN_GREEN | MAX_GREEN | YELLOW_T | ALLRED_T | WALK_T | FLASH_T) >> CNT_W) != 0)
  begin : g_bad_params
    $error("traffic_phase_scheduler: illegal timing parameters");
  end

  typedef enum logic [2:0] {
    ST_ALLRED,
    ST_MAIN_GREEN,
    ST_MAIN_YELLOW,
    ST_SIDE_GREEN,
    ST_SIDE_YELLOW,
    ST_WALK
`ifdef TRAFFIC_NIGHT_FLASH_EN
    , ST_FLASH
`endif
  } state_t;

  typedef enum logic [1:0] {D_MAIN, D_SIDE, D_WALK} dest_t;

  state_t           state, nxt;
  dest_t            dest;
  logic [CNT_W-1:0] cnt;
  logic             side_pend, ped_pend, ped_first;
  logic             night_on;
  logic [2:0]       t_lt, s_lt;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  localparam logic [CNT_W-1:0] FL_M1 = CNT_W'(FLASH_T - 1);
  logic flash_lit;

  // Flash blink phase: lit on entry, inverted every FLASH_T cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          flash_lit <= 1'b1;
    else if (state != ST_FLASH)                        flash_lit <= 1'b1;
    else if (nxt == ST_FLASH && cnt == FL_M1)          flash_lit <= ~flash_lit;
  end

  // Night request forces main green to yield once minimum green is met.
  always_comb night_on = night;
`else
  // No night mode in this build.
  always_comb night_on = 1'b0;
`endif

  // State, phase timer, pending flags and ALLRED destination registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ALLRED;
      cnt       <= '0;
      dest      <= D_MAIN;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      ped_first <= 1'b0;
    end else begin
      state <= nxt;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      // In FLASH the timer doubles as the blink divider.
      if (state == ST_FLASH && nxt == ST_FLASH && cnt == FL_M1) cnt <= '0;
      else
`endif
      if (nxt != state)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CNT_W'(1);

      // Clear wins over set on the edge that grants the service.
      side_pend <= (nxt == ST_SIDE_GREEN && state != ST_SIDE_GREEN) ? 1'b0 : (side_pend | side_req);
      ped_pend  <= (nxt == ST_WALK && state != ST_WALK) ? 1'b0 : (ped_pend | ped_req);

      if (state == ST_MAIN_YELLOW && nxt == ST_ALLRED) begin
        if (side_pend && ped_pend) begin
          dest      <= ped_first ? D_WALK : D_SIDE;
          ped_first <= ~ped_first;
        end else if (ped_pend)  dest <= D_WALK;
        else if (side_pend)     dest <= D_SIDE;
        else                    dest <= D_MAIN;
      end else if (nxt == ST_ALLRED && state != ST_ALLRED) begin
        dest <= D_MAIN;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    nxt = state;
    case (state)
      ST_ALLRED: if (cnt == AR_M1) begin
        case (dest)
          D_SIDE:  nxt = ST_SIDE_GREEN;
          D_WALK:  nxt = ST_WALK;
          default: nxt = ST_MAIN_GREEN;
        endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
        if (night) nxt = ST_FLASH;
`endif
      end
      ST_MAIN_GREEN:  if (cnt >= MIN_M1 && (side_pend || ped_pend || night_on)) nxt = ST_MAIN_YELLOW;
      ST_MAIN_YELLOW: if (cnt == YEL_M1) nxt = ST_ALLRED;
      ST_SIDE_GREEN:  if (cnt == MAX_M1 || (cnt >= MIN_M1 && !side_req)) nxt = ST_SIDE_YELLOW;
      ST_SIDE_YELLOW: if (cnt == YEL_M1) nxt = ST_ALLRED;
      ST_WALK:        if (cnt == WLK_M1) nxt = ST_ALLRED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH:       if (!night) nxt = ST_ALLRED;
`endif
      default:        nxt = ST_ALLRED;
    endcase
  end

  // Light, walk and busy decode from the registered state.
  always_comb begin
    t_lt = RED;
    s_lt = RED;
    walk = 1'b0;
    busy = 1'b1;
    case (state)
      ST_MAIN_GREEN:  begin t_lt = GRN; busy = 1'b0; end
      ST_MAIN_YELLOW: t_lt = YEL;
      ST_SIDE_GREEN:  s_lt = GRN;
      ST_SIDE_YELLOW: s_lt = YEL;
      ST_WALK:        walk = 1'b1;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      ST_FLASH: begin
        t_lt = flash_lit ? YEL : 3'b000;
        s_lt = flash_lit ? RED : 3'b000;
      end
`endif
      default: ;
    endcase
    T1 = t_lt;
    T2 = t_lt;
    S1 = s_lt;
    S2 = s_lt;
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: stimulus queues the expected
// light pattern for each upcoming edge; monitors pop and compare.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] T1, T2, S1, S2;
  logic       walk, busy;

  typedef struct {
    logic [2:0] t;
    logic [2:0] s;
    logic       w;
    logic       b;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  event probe;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_scheduler #(
    .MIN_GREEN(4), .MAX_GREEN(10), .YELLOW_T(2), .ALLRED_T(1),
    .WALK_T(5), .FLASH_T(4), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(1'b0),
`endif
    .side_req(side_req),
    .ped_req(ped_req),
    .T1(T1), .T2(T2), .S1(S1), .S2(S2),
    .walk(walk),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    logic [13:0] got, want;
    got  = {T1, T2, S1, S2, walk, busy};
    want = {e.t, e.t, e.s, e.s, e.w, e.b};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got T1=%b T2=%b S1=%b S2=%b walk=%b busy=%b, want T=%b S=%b walk=%b busy=%b",
               e.tag, $time, T1, T2, S1, S2, walk, busy, e.t, e.s, e.w, e.b);
    end
  endtask

  // Clocked monitor: compares after each active edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (q.size() > 0) check(q.pop_front());
  end

  // Between-edge monitor for the asynchronous reset check.
  initial forever begin
    @(probe);
    #1;
    if (aq.size() > 0) check(aq.pop_front());
  end

  // Drive inputs at the falling edge; queue the outputs expected after the next rising edge.
  task automatic step(input bit r, input bit s, input bit p,
                      input logic [2:0] t, input logic [2:0] sl,
                      input bit w, input bit b, input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = r; side_req = s; ped_req = p;
      e.t = t; e.s = sl; e.w = w; e.b = b; e.tag = tag;
      q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    // reset and release
    step(0,0,0, RED,RED,0,1, "reset", 3);
    step(1,0,0, GRN,RED,0,0, "release", 1);
    // gap-out
    step(1,1,0, GRN,RED,0,0, "gap_main_green", 1);
    step(1,0,0, GRN,RED,0,0, "gap_main_green", 2);
    step(1,0,0, YEL,RED,0,1, "gap_main_yellow", 2);
    step(1,0,0, RED,RED,0,1, "gap_allred", 1);
    step(1,0,0, RED,GRN,0,1, "gap_side_green", 4);
    step(1,0,0, RED,YEL,0,1, "gap_side_yellow", 2);
    step(1,0,0, RED,RED,0,1, "gap_allred2", 1);
    // idle rest
    step(1,0,0, GRN,RED,0,0, "idle", 50);
    // max-out
    step(1,1,0, GRN,RED,0,0, "max_main_green", 1);
    step(1,1,0, YEL,RED,0,1, "max_main_yellow", 2);
    step(1,1,0, RED,RED,0,1, "max_allred", 1);
    step(1,1,0, RED,GRN,0,1, "max_side_green", 10);
    step(1,0,0, RED,YEL,0,1, "max_side_yellow", 2);
    step(1,0,0, RED,RED,0,1, "max_allred2", 1);
    step(1,0,0, GRN,RED,0,0, "relatched_main", 4);
    step(1,0,0, YEL,RED,0,1, "relatched_yellow", 1);
    // fairness
    step(0,0,0, RED,RED,0,1, "reset2", 3);
    step(1,0,0, GRN,RED,0,0, "release2", 1);
    step(1,1,1, GRN,RED,0,0, "fair_main", 1);
    step(1,0,0, GRN,RED,0,0, "fair_main", 2);
    step(1,0,0, YEL,RED,0,1, "fair_yellow", 2);
    step(1,0,0, RED,RED,0,1, "fair_allred", 1);
    step(1,0,0, RED,GRN,0,1, "fair_side_first", 4);
    step(1,0,0, RED,YEL,0,1, "fair_side_yellow", 2);
    step(1,0,0, RED,RED,0,1, "fair_allred", 1);
    step(1,1,1, GRN,RED,0,0, "fair_main2", 1);
    step(1,0,0, GRN,RED,0,0, "fair_main2", 3);
    step(1,0,0, YEL,RED,0,1, "fair_yellow2", 2);
    step(1,0,0, RED,RED,0,1, "fair_allred2", 1);
    step(1,0,0, RED,RED,1,1, "fair_walk", 5);
    step(1,0,0, RED,RED,0,1, "fair_allred3", 1);
    step(1,0,0, GRN,RED,0,0, "fair_main3", 4);
    step(1,0,0, YEL,RED,0,1, "fair_yellow3", 2);
    step(1,0,0, RED,RED,0,1, "fair_allred4", 1);
    step(1,0,0, RED,GRN,0,1, "side_green", 4);
    step(1,0,0, RED,YEL,0,1, "side_yellow", 1);
    step(1,1,0, RED,YEL,0,1, "side_yellow", 1);
    // asynchronous reset between edges, mid side yellow with side_pend set
    @(negedge clk);
    #2;
    rst = 1'b0; side_req = 1'b0;
    e.t = RED; e.s = RED; e.w = 1'b0; e.b = 1'b1; e.tag = "async_reset";
    aq.push_back(e);
    q.push_back(e);
    ->probe;
    step(0,0,0, RED,RED,0,1, "async_hold", 2);
    step(1,0,0, GRN,RED,0,0, "after_release", 1);
    step(1,0,0, GRN,RED,0,0, "no_side_service", 12);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0 || aq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size() + aq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at %0t, want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
